// File: rtl/issue_entry_queue_if.sv
// Scoreboard entry type and the decode/issue handshake bundle for issue_entry_queue.
// ariane_pkg is reduced to the fields this queue carries; the queue treats the entry as opaque.
package ariane_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        use_imm;
    } scoreboard_entry_t;

endpackage

interface issue_entry_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
);
    logic                          flush_i;
    ariane_pkg::scoreboard_entry_t decoded_entry_i;
    logic                          decoded_valid_i;
    logic                          decoded_is_ctrl_flow_i;
    logic                          decoded_ack_o;
    ariane_pkg::scoreboard_entry_t issue_entry_o;
    logic                          issue_entry_valid_o;
    logic                          is_ctrl_flow_o;
    logic                          issue_instr_ack_i;
    logic [CNT_W-1:0]              count_o;

    modport master (
        output flush_i, decoded_entry_i, decoded_valid_i, decoded_is_ctrl_flow_i, issue_instr_ack_i,
        input  decoded_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o, count_o
    );

    modport slave (
        input  flush_i, decoded_entry_i, decoded_valid_i, decoded_is_ctrl_flow_i, issue_instr_ack_i,
        output decoded_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o, count_o
    );
endinterface

// File: rtl/issue_entry_queue.sv
// In-order decode-to-issue buffer: presents the oldest decoded entry and pops it on issue ack.
// Push is refused while full even if the same cycle pops; flush and reset clear the queue.
module issue_entry_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    issue_entry_queue_if.slave q_if
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        ariane_pkg::scoreboard_entry_t sbe;
        logic                          is_ctrl_flow;
    } slot_t;

    slot_t            mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full, empty, ack, push, pop;

    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        ack   = !full && !q_if.flush_i;
        push  = q_if.decoded_valid_i && ack;
        pop   = q_if.issue_instr_ack_i && !empty;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (q_if.flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; empty masks the head so stale slots never reach the outputs.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{sbe: q_if.decoded_entry_i, is_ctrl_flow: q_if.decoded_is_ctrl_flow_i};
        end
    end

    always_comb begin
        q_if.decoded_ack_o       = ack;
        q_if.issue_entry_valid_o = !empty;
        q_if.count_o             = count_q;
        q_if.issue_entry_o       = '0;
        q_if.is_ctrl_flow_o      = 1'b0;
        if (!empty) begin
            q_if.issue_entry_o  = mem_q[rd_ptr_q].sbe;
            q_if.is_ctrl_flow_o = mem_q[rd_ptr_q].is_ctrl_flow;
        end
    end

endmodule

// File: tb/tb_issue_entry_queue.sv
// Directed self-checking bench for issue_entry_queue with DEPTH=4.
module tb_issue_entry_queue;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    issue_entry_queue_if #(.DEPTH(4)) bus ();

    issue_entry_queue #(.DEPTH(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .q_if   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ariane_pkg::scoreboard_entry_t mk(input logic [4:0] rd);
        ariane_pkg::scoreboard_entry_t e;
        e         = '0;
        e.rd      = rd;
        e.rs1     = rd ^ 5'h1f;
        e.op      = {3'b101, rd};
        e.pc      = 32'h8000_0000 + {25'd0, rd, 2'b00};
        e.result  = {rd, 27'h5a5a5a5};
        e.use_imm = rd[0];
        return e;
    endfunction

    // Step to just after the next rising edge; inputs are driven here, checks follow a #1 settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_i                = 1'b0;
        bus.decoded_valid_i        = 1'b0;
        bus.decoded_entry_i        = '0;
        bus.decoded_is_ctrl_flow_i = 1'b0;
        bus.issue_instr_ack_i      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        #1;
        total++;
        if (bus.count_o !== 3'd0) begin
            bad++; $display("FAIL reset_hold_count: got %0d want 0", bus.count_o);
        end
        rst_n = 1'b1;
        tick();
        #1;
        total++;
        if (bus.issue_entry_valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b want 0", bus.issue_entry_valid_o);
        end
        total++;
        if (bus.count_o !== 3'd0) begin
            bad++; $display("FAIL reset_count: got %0d want 0", bus.count_o);
        end
        total++;
        if (bus.decoded_ack_o !== 1'b1) begin
            bad++; $display("FAIL reset_ack: got %b want 1", bus.decoded_ack_o);
        end
        total++;
        if (bus.issue_entry_o !== '0 || bus.is_ctrl_flow_o !== 1'b0) begin
            bad++; $display("FAIL reset_entry: got %h/%b want 0/0", bus.issue_entry_o, bus.is_ctrl_flow_o);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 5; i++) begin
            bus.decoded_valid_i = 1'b1;
            bus.decoded_entry_i = mk(5'(i));
            #1;
            total++;
            if (bus.decoded_ack_o !== (i <= 4)) begin
                bad++; $display("FAIL fill_ack[%0d]: got %b want %b", i, bus.decoded_ack_o, (i <= 4));
            end
            tick();
        end
        bus.decoded_valid_i = 1'b0;
        #1;
        total++;
        if (bus.count_o !== 3'd4) begin
            bad++; $display("FAIL fill_count: got %0d want 4", bus.count_o);
        end
        for (int i = 1; i <= 4; i++) begin
            bus.issue_instr_ack_i = 1'b1;
            #1;
            total++;
            if (bus.issue_entry_valid_o !== 1'b1 || bus.issue_entry_o !== mk(5'(i))) begin
                bad++; $display("FAIL drain_order[%0d]: got rd=%0d v=%b want rd=%0d v=1",
                                i, bus.issue_entry_o.rd, bus.issue_entry_valid_o, i);
            end
            tick();
        end
        bus.issue_instr_ack_i = 1'b0;
        #1;
        total++;
        if (bus.issue_entry_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin
            bad++; $display("FAIL drain_empty: got v=%b cnt=%0d want v=0 cnt=0",
                            bus.issue_entry_valid_o, bus.count_o);
        end
    endtask

    task automatic test_stream_wrap();
        bus.decoded_valid_i = 1'b1;
        bus.decoded_entry_i = mk(5'd10);
        tick();
        for (int k = 0; k < 10; k++) begin
            bus.decoded_valid_i   = 1'b1;
            bus.decoded_entry_i   = mk(5'(11 + k));
            bus.issue_instr_ack_i = 1'b1;
            #1;
            total++;
            if (bus.count_o !== 3'd1 || bus.decoded_ack_o !== 1'b1 || bus.issue_entry_o !== mk(5'(10 + k))) begin
                bad++; $display("FAIL stream[%0d]: got rd=%0d cnt=%0d ack=%b want rd=%0d cnt=1 ack=1",
                                k, bus.issue_entry_o.rd, bus.count_o, bus.decoded_ack_o, 10 + k);
            end
            tick();
        end
        bus.decoded_valid_i = 1'b0;
        #1;
        total++;
        if (bus.count_o !== 3'd1 || bus.issue_entry_o !== mk(5'd20)) begin
            bad++; $display("FAIL stream_last: got rd=%0d cnt=%0d want rd=20 cnt=1",
                            bus.issue_entry_o.rd, bus.count_o);
        end
        tick();
        bus.issue_instr_ack_i = 1'b0;
        #1;
        total++;
        if (bus.count_o !== 3'd0) begin
            bad++; $display("FAIL stream_drain: got cnt=%0d want 0", bus.count_o);
        end
    endtask

    task automatic test_full_ack();
        for (int i = 0; i < 4; i++) begin
            bus.decoded_valid_i = 1'b1;
            bus.decoded_entry_i = mk(5'(21 + i));
            tick();
        end
        bus.decoded_entry_i   = mk(5'd25);
        bus.issue_instr_ack_i = 1'b1;
        #1;
        total++;
        if (bus.decoded_ack_o !== 1'b0 || bus.count_o !== 3'd4) begin
            bad++; $display("FAIL full_ack_refuse: got ack=%b cnt=%0d want ack=0 cnt=4",
                            bus.decoded_ack_o, bus.count_o);
        end
        tick();
        bus.decoded_valid_i = 1'b0;
        #1;
        total++;
        if (bus.count_o !== 3'd3 || bus.issue_entry_o !== mk(5'd22)) begin
            bad++; $display("FAIL full_ack_after: got rd=%0d cnt=%0d want rd=22 cnt=3",
                            bus.issue_entry_o.rd, bus.count_o);
        end
        tick();
        tick();
        #1;
        total++;
        if (bus.issue_entry_o !== mk(5'd24) || bus.count_o !== 3'd1) begin
            bad++; $display("FAIL full_ack_tail: got rd=%0d cnt=%0d want rd=24 cnt=1",
                            bus.issue_entry_o.rd, bus.count_o);
        end
        tick();
        bus.issue_instr_ack_i = 1'b0;
        #1;
        total++;
        if (bus.count_o !== 3'd0 || bus.issue_entry_valid_o !== 1'b0) begin
            bad++; $display("FAIL full_ack_empty: got cnt=%0d v=%b want cnt=0 v=0",
                            bus.count_o, bus.issue_entry_valid_o);
        end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) begin
            bus.decoded_valid_i = 1'b1;
            bus.decoded_entry_i = mk(5'(i));
            tick();
        end
        bus.flush_i           = 1'b1;
        bus.decoded_entry_i   = mk(5'd9);
        bus.issue_instr_ack_i = 1'b1;
        #1;
        total++;
        if (bus.decoded_ack_o !== 1'b0) begin
            bad++; $display("FAIL flush_ack: got %b want 0", bus.decoded_ack_o);
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if (bus.count_o !== 3'd0 || bus.issue_entry_valid_o !== 1'b0 || bus.issue_entry_o !== '0) begin
            bad++; $display("FAIL flush_clear: got cnt=%0d v=%b rd=%0d want cnt=0 v=0 rd=0",
                            bus.count_o, bus.issue_entry_valid_o, bus.issue_entry_o.rd);
        end
        bus.decoded_valid_i = 1'b1;
        bus.decoded_entry_i = mk(5'd7);
        tick();
        bus.decoded_valid_i = 1'b0;
        #1;
        total++;
        if (bus.issue_entry_valid_o !== 1'b1 || bus.issue_entry_o !== mk(5'd7) || bus.count_o !== 3'd1) begin
            bad++; $display("FAIL flush_repush: got rd=%0d v=%b cnt=%0d want rd=7 v=1 cnt=1",
                            bus.issue_entry_o.rd, bus.issue_entry_valid_o, bus.count_o);
        end
        bus.issue_instr_ack_i = 1'b1;
        tick();
        bus.issue_instr_ack_i = 1'b0;
    endtask

    task automatic test_ctrl_flow_empty_ack();
        bus.decoded_valid_i        = 1'b1;
        bus.decoded_entry_i        = mk(5'd3);
        bus.decoded_is_ctrl_flow_i = 1'b1;
        tick();
        bus.decoded_entry_i        = mk(5'd4);
        bus.decoded_is_ctrl_flow_i = 1'b0;
        #1;
        total++;
        if (bus.is_ctrl_flow_o !== 1'b1) begin
            bad++; $display("FAIL ctrl_first: got %b want 1", bus.is_ctrl_flow_o);
        end
        tick();
        bus.decoded_valid_i   = 1'b0;
        bus.issue_instr_ack_i = 1'b1;
        tick();
        #1;
        total++;
        if (bus.is_ctrl_flow_o !== 1'b0 || bus.issue_entry_o !== mk(5'd4)) begin
            bad++; $display("FAIL ctrl_second: got ctrl=%b rd=%0d want ctrl=0 rd=4",
                            bus.is_ctrl_flow_o, bus.issue_entry_o.rd);
        end
        tick();
        tick();
        bus.issue_instr_ack_i = 1'b0;
        #1;
        total++;
        if (bus.count_o !== 3'd0 || bus.issue_entry_valid_o !== 1'b0) begin
            bad++; $display("FAIL empty_ack_count: got cnt=%0d v=%b want cnt=0 v=0",
                            bus.count_o, bus.issue_entry_valid_o);
        end
        bus.decoded_valid_i        = 1'b1;
        bus.decoded_entry_i        = mk(5'd5);
        bus.decoded_is_ctrl_flow_i = 1'b1;
        tick();
        idle_inputs();
        #1;
        total++;
        if (bus.issue_entry_o !== mk(5'd5) || bus.is_ctrl_flow_o !== 1'b1 || bus.count_o !== 3'd1) begin
            bad++; $display("FAIL empty_ack_ptr: got rd=%0d ctrl=%b cnt=%0d want rd=5 ctrl=1 cnt=1",
                            bus.issue_entry_o.rd, bus.is_ctrl_flow_o, bus.count_o);
        end
    endtask

    task automatic test_reset_mid();
        bus.decoded_valid_i = 1'b1;
        bus.decoded_entry_i = mk(5'd12);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle_inputs();
        #1;
        total++;
        if (bus.count_o !== 3'd0 || bus.issue_entry_valid_o !== 1'b0 || bus.decoded_ack_o !== 1'b1) begin
            bad++; $display("FAIL reset_mid: got cnt=%0d v=%b ack=%b want cnt=0 v=0 ack=1",
                            bus.count_o, bus.issue_entry_valid_o, bus.decoded_ack_o);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill_drain();
        test_stream_wrap();
        test_full_ack();
        test_flush();
        test_ctrl_flow_empty_ack();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
